// File: rtl/lsu_axil_master.sv
// Load/store unit for nano_rv32i: local dmem byte-lane access or AXI-Lite MMIO master.
// Optional AXI watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_axil_master #(
    parameter int unsigned        ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  MMIO_BASE   = ADDR_W'(32'h3000_0000),
    parameter logic [ADDR_W-1:0]  MMIO_MASK   = ADDR_W'(32'hFF00_0000),
    parameter int unsigned        DMEM_LAT    = 1,
    parameter int unsigned        TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_we_o,
    output logic              dmem_re_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int unsigned LAT_W = (DMEM_LAT < 1) ? 1 : $clog2(DMEM_LAT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DMEM_WR  = 3'd1;
    localparam logic [2:0] S_DMEM_RD  = 3'd2;
    localparam logic [2:0] S_AXI_AW_W = 3'd3;
    localparam logic [2:0] S_AXI_B    = 3'd4;
    localparam logic [2:0] S_AXI_AR   = 3'd5;
    localparam logic [2:0] S_AXI_R    = 3'd6;
    localparam logic [2:0] S_RESP     = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] axi_addr_q, axi_addr_d;
    logic [ADDR_W-1:0] dmem_addr_d;
    logic [31:0]       st_data_q, st_data_d;
    logic [3:0]        wstrb_d, dmem_we_d;
    logic [31:0]       resp_rdata_d;
    logic              req_ready_d, resp_valid_d, resp_err_d, dmem_re_d;
    logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic              aw_pend, w_pend;

    logic              misaligned_c;
    logic              mmio_hit_c;
    logic [3:0]        lane_mask_c;
    logic [31:0]       st_shift_c;

    logic              unused_resp_lsb;
    assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

    // Shift the selected lane down and sign/zero-extend by access size.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3,
                                           input logic [1:0] lane);
        logic [31:0] sh;
        sh = raw >> {lane, 3'b000};
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'd0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return f3[2] ? {16'd0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: return raw;
        endcase
    endfunction

    // Request decode on the raw inputs; only meaningful on the accept cycle.
    always_comb begin
        misaligned_c = 1'b1;
        lane_mask_c  = 4'hF;
        st_shift_c   = wdata_i;
        case (funct3_i)
            3'b000:  misaligned_c = 1'b0;
            3'b001:  misaligned_c = addr_i[0];
            3'b010:  misaligned_c = (addr_i[1:0] != 2'b00);
            3'b100:  misaligned_c = req_we_i;
            3'b101:  misaligned_c = req_we_i | addr_i[0];
            default: misaligned_c = 1'b1;
        endcase
        case (funct3_i[1:0])
            2'b00: begin
                lane_mask_c = 4'b0001 << addr_i[1:0];
                st_shift_c  = 32'(wdata_i[7:0]) << {addr_i[1:0], 3'b000};
            end
            2'b01: begin
                lane_mask_c = 4'b0011 << addr_i[1:0];
                st_shift_c  = 32'(wdata_i[15:0]) << {addr_i[1:0], 3'b000};
            end
            default: begin
                lane_mask_c = 4'hF;
                st_shift_c  = wdata_i;
            end
        endcase
        mmio_hit_c = ((addr_i & MMIO_MASK) == MMIO_BASE);
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             in_axi_c;
    assign in_axi_c = (state_q == S_AXI_AW_W) || (state_q == S_AXI_B) ||
                      (state_q == S_AXI_AR)   || (state_q == S_AXI_R);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // Next-state and next-output logic; pulses default low, AXI payload holds.
    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        lat_cnt_d    = lat_cnt_q;
        axi_addr_d   = axi_addr_q;
        dmem_addr_d  = dmem_addr_o;
        st_data_d    = st_data_q;
        wstrb_d      = m_axi_wstrb;
        dmem_we_d    = 4'd0;
        dmem_re_d    = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        awvalid_d    = m_axi_awvalid;
        wvalid_d     = m_axi_wvalid;
        bready_d     = m_axi_bready;
        arvalid_d    = m_axi_arvalid;
        rready_d     = m_axi_rready;
        aw_pend      = m_axi_awvalid & ~m_axi_awready;
        w_pend       = m_axi_wvalid & ~m_axi_wready;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    f3_d        = funct3_i;
                    lane_d      = addr_i[1:0];
                    lat_cnt_d   = '0;
                    axi_addr_d  = addr_i;
                    dmem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
                    st_data_d   = st_shift_c;
                    wstrb_d     = lane_mask_c;
                    if (misaligned_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (mmio_hit_c && req_we_i) begin
                        state_d   = S_AXI_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else if (mmio_hit_c) begin
                        state_d   = S_AXI_AR;
                        arvalid_d = 1'b1;
                    end else if (req_we_i) begin
                        state_d   = S_DMEM_WR;
                        dmem_we_d = lane_mask_c;
                    end else begin
                        state_d   = S_DMEM_RD;
                        dmem_re_d = 1'b1;
                    end
                end
            end
            S_DMEM_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_DMEM_RD: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_W'(DMEM_LAT)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extend(dmem_rdata_i, f3_q, lane_q);
                end
            end
            S_AXI_AW_W: begin
                awvalid_d = aw_pend;
                wvalid_d  = w_pend;
                if (!aw_pend && !w_pend) begin
                    state_d  = S_AXI_B;
                    bready_d = 1'b1;
                end
            end
            S_AXI_B: begin
                if (m_axi_bvalid) begin
                    state_d      = S_RESP;
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = m_axi_bresp[1];
                end
            end
            S_AXI_AR: begin
                if (m_axi_arready) begin
                    state_d   = S_AXI_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_AXI_R: begin
                if (m_axi_rvalid) begin
                    state_d      = S_RESP;
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = m_axi_rresp[1];
                    resp_rdata_d = extend(m_axi_rdata, f3_q, lane_q);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef LSU_TIMEOUT_EN
        // Watchdog: abandon a stalled AXI transfer after TIMEOUT_CYC cycles in one state.
        tmo_cnt_d = '0;
        if (in_axi_c && state_d == state_q) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_d      = S_RESP;
                awvalid_d    = 1'b0;
                wvalid_d     = 1'b0;
                bready_d     = 1'b0;
                arvalid_d    = 1'b0;
                rready_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = 32'd0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            f3_q          <= 3'd0;
            lane_q        <= 2'd0;
            lat_cnt_q     <= '0;
            axi_addr_q    <= '0;
            st_data_q     <= 32'd0;
            req_ready_o   <= 1'b1;
            resp_valid_o  <= 1'b0;
            resp_rdata_o  <= 32'd0;
            resp_err_o    <= 1'b0;
            dmem_addr_o   <= '0;
            dmem_we_o     <= 4'd0;
            dmem_re_o     <= 1'b0;
            m_axi_wstrb   <= 4'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            f3_q          <= f3_d;
            lane_q        <= lane_d;
            lat_cnt_q     <= lat_cnt_d;
            axi_addr_q    <= axi_addr_d;
            st_data_q     <= st_data_d;
            req_ready_o   <= req_ready_d;
            resp_valid_o  <= resp_valid_d;
            resp_rdata_o  <= resp_rdata_d;
            resp_err_o    <= resp_err_d;
            dmem_addr_o   <= dmem_addr_d;
            dmem_we_o     <= dmem_we_d;
            dmem_re_o     <= dmem_re_d;
            m_axi_wstrb   <= wstrb_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    // Address and store data come straight from their flops on both buses.
    assign m_axi_awaddr = axi_addr_q;
    assign m_axi_araddr = axi_addr_q;
    assign m_axi_wdata  = st_data_q;
    assign dmem_wdata_o = st_data_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master: vector table plus AXI handshake and reset sequences.
module tb_lsu_axil_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_we_o;
    logic        dmem_re_o;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    lsu_axil_master #(.ADDR_W(32), .DMEM_LAT(1), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o), .dmem_re_o(dmem_re_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // kind: 0 = no bus activity (error), 1 = local dmem, 2 = AXI
    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  rsp;
        int          kind;
        int          lat;
        logic        err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(string nm, logic we, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, logic [1:0] rsp, int kind,
                                int lat, logic err, logic [31:0] er, logic [3:0] es,
                                logic [31:0] ew);
        vec_t v;
        v.name = nm; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.rsp = rsp; v.kind = kind; v.lat = lat; v.err = err; v.exp_rdata = er;
        v.exp_strb = es; v.exp_wdata = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("req_ready before accept", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat, we_cycles;
        logic        saw_dmem, saw_axi, got_err;
        logic [3:0]  cap_strb;
        logic [31:0] cap_wd, got_rdata;
        lat = 0; we_cycles = 0; saw_dmem = 0; saw_axi = 0; got_err = 0;
        cap_strb = 4'd0; cap_wd = 32'd0; got_rdata = 32'd0;
        dmem_rdata_i = v.rdata; m_axi_rdata = v.rdata;
        m_axi_bresp = v.rsp; m_axi_rresp = v.rsp;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
        start_req(v.we, v.f3, v.addr, v.wdata);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk_i);
            if (dmem_we_o != 4'd0) begin
                saw_dmem = 1; we_cycles++; cap_strb = dmem_we_o; cap_wd = dmem_wdata_o;
            end
            if (dmem_re_o) saw_dmem = 1;
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) saw_axi = 1;
            if (m_axi_wvalid) begin
                cap_strb = m_axi_wstrb; cap_wd = m_axi_wdata;
            end
            m_axi_bvalid = m_axi_bready;
            m_axi_rvalid = m_axi_rready;
            if (resp_valid_o) begin
                lat = cyc; got_err = resp_err_o; got_rdata = resp_rdata_o;
                break;
            end
        end
        chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, " err"}, 32'(got_err), 32'(v.err));
        chk({v.name, " rdata"}, got_rdata, v.exp_rdata);
        chk({v.name, " dmem activity"}, 32'(saw_dmem), 32'(v.kind == 1));
        chk({v.name, " axi activity"}, 32'(saw_axi), 32'(v.kind == 2));
        chk({v.name, " strobe"}, 32'(cap_strb), 32'(v.exp_strb));
        if (v.exp_strb != 4'd0) chk({v.name, " wdata"}, cap_wd, v.exp_wdata);
        if (v.kind == 1 && v.we) chk({v.name, " we cycles"}, 32'(we_cycles), 32'd1);
        @(negedge clk_i);
        chk({v.name, " resp pulse"}, 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk("SB local",    1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,         2'b00, 1, 2, 0, 32'h0,         4'b1000, 32'hA500_0000);
        vecs[1]  = mk("LB local",    0, 3'b000, 32'h0000_0102, 32'h0,         32'h0080_0000, 2'b00, 1, 3, 0, 32'hFFFF_FF80, 4'b0000, 32'h0);
        vecs[2]  = mk("LBU local",   0, 3'b100, 32'h0000_0102, 32'h0,         32'h0080_0000, 2'b00, 1, 3, 0, 32'h0000_0080, 4'b0000, 32'h0);
        vecs[3]  = mk("LH local",    0, 3'b001, 32'h0000_0202, 32'h0,         32'h8001_0000, 2'b00, 1, 3, 0, 32'hFFFF_8001, 4'b0000, 32'h0);
        vecs[4]  = mk("LHU local",   0, 3'b101, 32'h0000_0202, 32'h0,         32'h8001_0000, 2'b00, 1, 3, 0, 32'h0000_8001, 4'b0000, 32'h0);
        vecs[5]  = mk("LW local",    0, 3'b010, 32'h0000_0204, 32'h0,         32'h1234_5678, 2'b00, 1, 3, 0, 32'h1234_5678, 4'b0000, 32'h0);
        vecs[6]  = mk("SH local",    1, 3'b001, 32'h0000_0106, 32'hBEEF_CAFE, 32'h0,         2'b00, 1, 2, 0, 32'h0,         4'b1100, 32'hCAFE_0000);
        vecs[7]  = mk("SW local",    1, 3'b010, 32'h0000_0108, 32'h0102_0304, 32'h0,         2'b00, 1, 2, 0, 32'h0,         4'b1111, 32'h0102_0304);
        vecs[8]  = mk("LH misalign", 0, 3'b001, 32'h0000_0201, 32'h0,         32'hFFFF_FFFF, 2'b00, 0, 1, 1, 32'h0,         4'b0000, 32'h0);
        vecs[9]  = mk("SW misalign", 1, 3'b010, 32'h0000_010A, 32'h1111_2222, 32'h0,         2'b00, 0, 1, 1, 32'h0,         4'b0000, 32'h0);
        vecs[10] = mk("f3 011 load", 0, 3'b011, 32'h0000_0100, 32'h0,         32'h5555_5555, 2'b00, 0, 1, 1, 32'h0,         4'b0000, 32'h0);
        vecs[11] = mk("f3 100 store",1, 3'b100, 32'h0000_0100, 32'h0000_0077, 32'h0,         2'b00, 0, 1, 1, 32'h0,         4'b0000, 32'h0);
        vecs[12] = mk("SB mmio",     1, 3'b000, 32'h3000_0021, 32'h0000_005A, 32'h0,         2'b00, 2, 3, 0, 32'h0,         4'b0010, 32'h0000_5A00);
        vecs[13] = mk("LB mmio",     0, 3'b000, 32'h3000_0013, 32'h0,         32'hC300_1122, 2'b00, 2, 3, 0, 32'hFFFF_FFC3, 4'b0000, 32'h0);
        vecs[14] = mk("SW decerr",   1, 3'b010, 32'h3000_0030, 32'hCAFE_BABE, 32'h0,         2'b11, 2, 3, 1, 32'h0,         4'b1111, 32'hCAFE_BABE);
        vecs[15] = mk("LW slverr",   0, 3'b010, 32'h3000_0040, 32'h0,         32'h0BAD_F00D, 2'b10, 2, 3, 1, 32'h0BAD_F00D, 4'b0000, 32'h0);
        vecs[16] = mk("LW above mmio",0,3'b010, 32'h3100_0000, 32'h0,         32'hAAAA_5555, 2'b00, 1, 3, 0, 32'hAAAA_5555, 4'b0000, 32'h0);
        vecs[17] = mk("SW mmio top", 1, 3'b010, 32'h30FF_FFFC, 32'h0F0F_F0F0, 32'h0,         2'b00, 2, 3, 0, 32'h0,         4'b1111, 32'h0F0F_F0F0);

        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; funct3_i = 3'd0;
        addr_i = 32'd0; wdata_i = 32'd0; dmem_rdata_i = 32'd0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_rresp = 2'b00;
        m_axi_rdata = 32'd0;
        repeat (2) @(negedge clk_i);
        chk("reset req_ready", 32'(req_ready_o), 32'd1);
        chk("reset resp_valid", 32'(resp_valid_o), 32'd0);
        chk("reset valids", {28'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready}, 32'd0);
        chk("reset dmem", {27'd0, dmem_we_o, dmem_re_o}, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // MMIO SW: awready two cycles ahead of wready; wvalid must hold.
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        start_req(1'b1, 3'b010, 32'h3000_0010, 32'h0000_1234);
        @(negedge clk_i);
        chk("aw_w c1 valids", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
        chk("aw_w awaddr", m_axi_awaddr, 32'h3000_0010);
        chk("aw_w wstrb", 32'(m_axi_wstrb), 32'hF);
        m_axi_awready = 1'b1;
        @(negedge clk_i);
        chk("aw_w c2 valids", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd1);
        m_axi_awready = 1'b0;
        @(negedge clk_i);
        chk("aw_w c3 wvalid held", 32'(m_axi_wvalid), 32'd1);
        chk("aw_w c3 wdata", m_axi_wdata, 32'h0000_1234);
        m_axi_wready = 1'b1;
        @(negedge clk_i);
        chk("aw_w c4 wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("aw_w c4 bready", 32'(m_axi_bready), 32'd1);
        chk("aw_w c4 early resp", 32'(resp_valid_o), 32'd0);
        m_axi_wready = 1'b0; m_axi_bvalid = 1'b1;
        @(negedge clk_i);
        chk("aw_w c5 resp", {30'd0, resp_valid_o, resp_err_o}, 32'd2);
        chk("aw_w c5 bready", 32'(m_axi_bready), 32'd0);
        m_axi_bvalid = 1'b0;
        @(negedge clk_i);
        chk("aw_w c6 single pulse", 32'(resp_valid_o), 32'd0);
        chk("aw_w c6 ready", 32'(req_ready_o), 32'd1);

        // MMIO LW: rvalid five cycles after arready, SLVERR.
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        start_req(1'b0, 3'b010, 32'h3000_0004, 32'h0);
        @(negedge clk_i);
        chk("ar c1 arvalid", 32'(m_axi_arvalid), 32'd1);
        chk("ar araddr", m_axi_araddr, 32'h3000_0004);
        m_axi_arready = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk_i);
            m_axi_arready = 1'b0;
            chk("r wait rready", {30'd0, m_axi_rready, resp_valid_o}, 32'd2);
        end
        m_axi_rvalid = 1'b1; m_axi_rresp = 2'b10; m_axi_rdata = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("r resp", {30'd0, resp_valid_o, resp_err_o}, 32'd3);
        chk("r rdata", resp_rdata_o, 32'hDEAD_BEEF);
        m_axi_rvalid = 1'b0;
        @(negedge clk_i);
        chk("r single pulse", 32'(resp_valid_o), 32'd0);

        // Reset in the middle of a stalled read.
        m_axi_arready = 1'b0;
        start_req(1'b0, 3'b010, 32'h3000_0008, 32'h0);
        repeat (3) @(negedge clk_i);
        chk("stall arvalid", 32'(m_axi_arvalid), 32'd1);
        chk("stall araddr", m_axi_araddr, 32'h3000_0008);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid reset arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("mid reset ready", 32'(req_ready_o), 32'd1);
        rst_i = 1'b0;

`ifdef LSU_TIMEOUT_EN
        begin
            int lat_t;
            lat_t = 0;
            m_axi_arready = 1'b0;
            start_req(1'b0, 3'b010, 32'h3000_000C, 32'h0);
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk_i);
                if (resp_valid_o) begin
                    lat_t = c;
                    chk("timeout err", 32'(resp_err_o), 32'd1);
                    chk("timeout rdata", resp_rdata_o, 32'd0);
                    chk("timeout arvalid", 32'(m_axi_arvalid), 32'd0);
                    break;
                end
            end
            chk("timeout latency", 32'(lat_t), 32'd17);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
